// File: rtl/kws_pkg.sv
// ============================================================================
// Module : kws_pkg
// Brief  : Shared encodings for the keyword-search verdict path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package kws_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE     = 2'd0;
  localparam seq_state_t ST_ISSUE    = 2'd1;
  localparam seq_state_t ST_WAIT_EOM = 2'd2;

  localparam logic VERDICT_ALLOW = 1'b1;
  localparam logic VERDICT_DENY  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/verdict_fifo.sv
// ============================================================================
// Module : verdict_fifo
// Brief  : Synchronous FIFO with full/empty flags and a registered ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module verdict_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ready_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             ready_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign ready_o   = ready_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_push   = wr_en_i && !full_o;
  assign do_pop    = rd_en_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Ready is computed from the next occupancy so it is exact yet registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
    end
  end

endmodule

`default_nettype wire

// File: rtl/verdict_sequencer.sv
// ============================================================================
// Module : verdict_sequencer
// Brief  : Queues allow/deny verdicts and issues one per message to the gate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module verdict_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 verdict_valid,
  input  logic                 verdict_allow,
  output logic                 verdict_ready,
  output logic                 allow_sig,
  output logic                 deny_sig,
  input  logic                 ack,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  input  logic                 stat_clear,
  output logic [CNT_WIDTH-1:0] allow_count,
  output logic [CNT_WIDTH-1:0] deny_count,
  output logic [CNT_WIDTH-1:0] timeout_count,
  output logic                 err_timeout
);

  import kws_pkg::*;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]        TMR_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0]        TMR_ONE  = TW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  seq_state_t           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 allow_sig_q, allow_sig_d;
  logic                 deny_sig_q, deny_sig_d;
  logic [CNT_WIDTH-1:0] allow_cnt_q, allow_cnt_d;
  logic [CNT_WIDTH-1:0] deny_cnt_q, deny_cnt_d;
  logic [CNT_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                 err_q, err_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_ready;
  logic [0:0] head;
  logic       push;
  logic       pop;
  logic       eom_beat;
  logic       acked;
  logic       timeout_hit;

  assign push        = verdict_valid && fifo_ready && !fifo_full;
  assign eom_beat    = mon_tvalid && mon_tready && mon_tlast;
  assign acked       = (state_q == ST_ISSUE) && ack;
  assign timeout_hit = (state_q == ST_ISSUE) && !ack && (timer_q == TMR_LAST);
  assign pop         = acked || timeout_hit;

  verdict_fifo #(
    .WIDTH (1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (push),
    .wr_data_i (verdict_allow),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .ready_o   (fifo_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // A tlast beat in the ack cycle closes a single-beat message at once.
        if (ack) begin
          state_d = eom_beat ? ST_IDLE : ST_WAIT_EOM;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_EOM: begin
        if (eom_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    allow_sig_d = 1'b0;
    deny_sig_d  = 1'b0;
    timer_d     = '0;
    if ((state_q == ST_ISSUE) && !pop) begin
      allow_sig_d = (head == VERDICT_ALLOW);
      deny_sig_d  = (head == VERDICT_DENY);
      timer_d     = timer_q + TMR_ONE;
    end
  end

  always_comb begin
    allow_cnt_d = allow_cnt_q;
    deny_cnt_d  = deny_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q || timeout_hit;
    if (acked && (head == VERDICT_ALLOW) && (allow_cnt_q != CNT_MAX)) begin
      allow_cnt_d = allow_cnt_q + CNT_ONE;
    end
    if (acked && (head == VERDICT_DENY) && (deny_cnt_q != CNT_MAX)) begin
      deny_cnt_d = deny_cnt_q + CNT_ONE;
    end
    if (timeout_hit && (to_cnt_q != CNT_MAX)) begin
      to_cnt_d = to_cnt_q + CNT_ONE;
    end
    if (stat_clear) begin
      allow_cnt_d = '0;
      deny_cnt_d  = '0;
      to_cnt_d    = '0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer_q     <= '0;
      allow_sig_q <= 1'b0;
      deny_sig_q  <= 1'b0;
      allow_cnt_q <= '0;
      deny_cnt_q  <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      allow_sig_q <= allow_sig_d;
      deny_sig_q  <= deny_sig_d;
      allow_cnt_q <= allow_cnt_d;
      deny_cnt_q  <= deny_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
    end
  end

  assign verdict_ready = fifo_ready;
  assign allow_sig     = allow_sig_q;
  assign deny_sig      = deny_sig_q;
  assign allow_count   = allow_cnt_q;
  assign deny_count    = deny_cnt_q;
  assign timeout_count = to_cnt_q;
  assign err_timeout   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_verdict_sequencer.sv
// ============================================================================
// Module : tb_verdict_sequencer
// Brief  : Directed self-checking bench for verdict_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_verdict_sequencer;

  localparam int CW = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic verdict_valid = 1'b0;
  logic verdict_allow = 1'b0;
  logic ack = 1'b0;
  logic mon_tvalid = 1'b0;
  logic mon_tready = 1'b0;
  logic mon_tlast = 1'b0;
  logic stat_clear = 1'b0;
  logic verdict_ready, allow_sig, deny_sig, err_timeout;
  logic [CW-1:0] allow_count, deny_count, timeout_count;

  int errors = 0;
  int checks = 0;
  int exp_allow = 0;
  int exp_deny = 0;
  int exp_to = 0;

  verdict_sequencer #(
    .FIFO_DEPTH  (4),
    .ACK_TIMEOUT (8),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .verdict_valid (verdict_valid),
    .verdict_allow (verdict_allow),
    .verdict_ready (verdict_ready),
    .allow_sig     (allow_sig),
    .deny_sig      (deny_sig),
    .ack           (ack),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tlast     (mon_tlast),
    .stat_clear    (stat_clear),
    .allow_count   (allow_count),
    .deny_count    (deny_count),
    .timeout_count (timeout_count),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Stimulus helpers: all drive and return at a negedge.
  task automatic push(input logic a);
    verdict_valid = 1'b1;
    verdict_allow = a;
    @(negedge clk);
    verdict_valid = 1'b0;
  endtask

  task automatic wait_sig(output int cyc);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (allow_sig || deny_sig) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack_pulse(input logic with_eom);
    ack        = 1'b1;
    mon_tvalid = with_eom;
    mon_tready = with_eom;
    mon_tlast  = with_eom;
    @(negedge clk);
    ack        = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({allow_sig, deny_sig, verdict_ready, err_timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs: got %b required 0000", {allow_sig, deny_sig, verdict_ready, err_timeout});
    end
    checks++;
    if ({allow_count, deny_count, timeout_count} !== '0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d/%0d required 0/0/0", allow_count, deny_count, timeout_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (verdict_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", verdict_ready);
    end
  endtask

  task automatic test_single_allow;
    logic [1:0] s0, s1;
    push(1'b1);
    s0 = {allow_sig, deny_sig};
    @(negedge clk);
    s1 = {allow_sig, deny_sig};
    checks++;
    if ({s0, s1} !== 4'b0000) begin
      errors++;
      $display("FAIL single_latency: got %b required 0000", {s0, s1});
    end
    @(negedge clk);
    checks++;
    if ({allow_sig, deny_sig} !== 2'b10) begin
      errors++;
      $display("FAIL single_issue: got %b required 10", {allow_sig, deny_sig});
    end
    ack_pulse(1'b0);
    exp_allow = sat(exp_allow + 1);
    checks++;
    if ({allow_sig, deny_sig} !== 2'b00 || allow_count !== CW'(exp_allow)) begin
      errors++;
      $display("FAIL single_ack: got sig=%b cnt=%0d required sig=00 cnt=%0d", {allow_sig, deny_sig}, allow_count, exp_allow);
    end
    ack_pulse(1'b0);
    checks++;
    if (allow_count !== CW'(exp_allow) || deny_count !== CW'(exp_deny)) begin
      errors++;
      $display("FAIL stray_ack: got %0d/%0d required %0d/%0d", allow_count, deny_count, exp_allow, exp_deny);
    end
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    repeat (3) @(negedge clk);
    mon_tlast = 1'b1;
    @(negedge clk);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic seen;
    verdict_valid = 1'b1;
    verdict_allow = 1'b0;
    @(negedge clk);
    verdict_allow = 1'b1;
    @(negedge clk);
    verdict_allow = 1'b0;
    @(negedge clk);
    verdict_valid = 1'b0;
    checks++;
    if ({allow_sig, deny_sig} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first: got %b required 01", {allow_sig, deny_sig});
    end
    ack_pulse(1'b0);
    exp_deny = sat(exp_deny + 1);
    seen = 1'b0;
    repeat (4) begin
      seen = seen | allow_sig | deny_sig;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait_eom: got sig=%b required 0", seen);
    end
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = 1'b1;
    @(negedge clk);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    wait_sig(cyc);
    checks++;
    if (cyc != 2 || {allow_sig, deny_sig} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_second: got cyc=%0d sig=%b required cyc=2 sig=10", cyc, {allow_sig, deny_sig});
    end
    ack_pulse(1'b1);
    exp_allow = sat(exp_allow + 1);
    wait_sig(cyc);
    checks++;
    if (cyc != 2 || {allow_sig, deny_sig} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_third: got cyc=%0d sig=%b required cyc=2 sig=01", cyc, {allow_sig, deny_sig});
    end
    ack_pulse(1'b1);
    exp_deny = sat(exp_deny + 1);
    checks++;
    if (deny_count !== CW'(exp_deny) || allow_count !== CW'(exp_allow)) begin
      errors++;
      $display("FAIL b2b_counts: got %0d/%0d required %0d/%0d", allow_count, deny_count, exp_allow, exp_deny);
    end
  endtask

  task automatic test_fifo_full;
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int cyc;
    logic seen;
    for (int i = 0; i < 4; i++) begin
      verdict_valid = 1'b1;
      verdict_allow = pat[i];
      @(negedge clk);
    end
    checks++;
    if (verdict_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b required 0", verdict_ready);
    end
    verdict_allow = pat[4];
    @(negedge clk);
    checks++;
    if (verdict_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: got %b required 0", verdict_ready);
    end
    for (int i = 0; i < 5; i++) begin
      wait_sig(cyc);
      checks++;
      if (cyc < 0 || {allow_sig, deny_sig} !== {pat[i], ~pat[i]}) begin
        errors++;
        $display("FAIL full_order[%0d]: got cyc=%0d sig=%b required sig=%b", i, cyc, {allow_sig, deny_sig}, {pat[i], ~pat[i]});
      end
      ack_pulse(1'b1);
      if (pat[i]) exp_allow = sat(exp_allow + 1);
      else        exp_deny  = sat(exp_deny + 1);
      if (i == 0) begin
        checks++;
        if (verdict_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_reopen: got %b required 1", verdict_ready);
        end
        @(negedge clk);
        verdict_valid = 1'b0;
      end
    end
    seen = 1'b0;
    repeat (5) begin
      seen = seen | allow_sig | deny_sig;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0 || deny_count !== CW'(exp_deny) || allow_count !== CW'(exp_allow)) begin
      errors++;
      $display("FAIL full_drain: got sig=%b cnt=%0d/%0d required sig=0 cnt=%0d/%0d", seen, allow_count, deny_count, exp_allow, exp_deny);
    end
  endtask

  task automatic test_timeout;
    int n;
    int cyc;
    push(1'b1);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (allow_sig) n++;
      @(negedge clk);
    end
    exp_to = sat(exp_to + 1);
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL timeout_len: got %0d high cycles required 7", n);
    end
    checks++;
    if (timeout_count !== CW'(exp_to) || err_timeout !== 1'b1 || allow_count !== CW'(exp_allow)) begin
      errors++;
      $display("FAIL timeout_stats: got to=%0d err=%b allow=%0d required to=%0d err=1 allow=%0d", timeout_count, err_timeout, allow_count, exp_to, exp_allow);
    end
    push(1'b0);
    wait_sig(cyc);
    checks++;
    if (cyc != 2 || {allow_sig, deny_sig} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_next: got cyc=%0d sig=%b required cyc=2 sig=01", cyc, {allow_sig, deny_sig});
    end
    ack_pulse(1'b1);
    exp_deny = sat(exp_deny + 1);
    // Ack lands on the very edge where the timer would expire.
    push(1'b1);
    wait_sig(cyc);
    repeat (6) @(negedge clk);
    ack_pulse(1'b1);
    exp_allow = sat(exp_allow + 1);
    checks++;
    if (timeout_count !== CW'(exp_to) || allow_count !== CW'(exp_allow) || {allow_sig, deny_sig} !== 2'b00) begin
      errors++;
      $display("FAIL ack_priority: got to=%0d allow=%0d sig=%b required to=%0d allow=%0d sig=00", timeout_count, allow_count, {allow_sig, deny_sig}, exp_to, exp_allow);
    end
  endtask

  task automatic test_enable;
    int cyc;
    logic seen;
    enable = 1'b0;
    push(1'b1);
    seen = 1'b0;
    repeat (5) begin
      seen = seen | allow_sig | deny_sig;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL enable_hold: got sig=%b required 0", seen);
    end
    enable = 1'b1;
    wait_sig(cyc);
    checks++;
    if (cyc != 2 || {allow_sig, deny_sig} !== 2'b10) begin
      errors++;
      $display("FAIL enable_resume: got cyc=%0d sig=%b required cyc=2 sig=10", cyc, {allow_sig, deny_sig});
    end
    ack_pulse(1'b1);
    exp_allow = sat(exp_allow + 1);
  endtask

  task automatic test_saturation;
    int cyc;
    for (int i = 0; i < 12; i++) begin
      push(1'b1);
      wait_sig(cyc);
      ack_pulse(1'b1);
      exp_allow = sat(exp_allow + 1);
    end
    checks++;
    if (allow_count !== 4'hF || exp_allow != CMAX) begin
      errors++;
      $display("FAIL saturate: got %0d required 15", allow_count);
    end
  endtask

  task automatic test_clear;
    int cyc;
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b required 1", err_timeout);
    end
    push(1'b1);
    wait_sig(cyc);
    stat_clear = 1'b1;
    ack_pulse(1'b1);
    stat_clear = 1'b0;
    exp_allow = 0;
    exp_deny  = 0;
    exp_to    = 0;
    checks++;
    if ({allow_count, deny_count, timeout_count} !== '0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: got %0d/%0d/%0d err=%b required 0/0/0 err=0", allow_count, deny_count, timeout_count, err_timeout);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic seen;
    push(1'b1);
    push(1'b0);
    push(1'b1);
    push(1'b0);
    wait_sig(cyc);
    ack_pulse(1'b0);
    checks++;
    if (allow_count !== 4'd1) begin
      errors++;
      $display("FAIL mid_pre: got %0d required 1", allow_count);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({allow_sig, deny_sig, verdict_ready, err_timeout} !== 4'b0000 || {allow_count, deny_count, timeout_count} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got outs=%b cnt=%0d/%0d/%0d required 0000 0/0/0", {allow_sig, deny_sig, verdict_ready, err_timeout}, allow_count, deny_count, timeout_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (verdict_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready: got %b required 1", verdict_ready);
    end
    seen = 1'b0;
    repeat (6) begin
      seen = seen | allow_sig | deny_sig;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_flushed: got sig=%b required 0", seen);
    end
    push(1'b0);
    wait_sig(cyc);
    checks++;
    if (cyc != 2 || {allow_sig, deny_sig} !== 2'b01) begin
      errors++;
      $display("FAIL mid_after: got cyc=%0d sig=%b required cyc=2 sig=01", cyc, {allow_sig, deny_sig});
    end
    ack_pulse(1'b1);
    seen = 1'b0;
    repeat (6) begin
      seen = seen | allow_sig | deny_sig;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0 || deny_count !== 4'd1) begin
      errors++;
      $display("FAIL mid_empty: got sig=%b deny=%0d required sig=0 deny=1", seen, deny_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_allow();
    test_back_to_back();
    test_fifo_full();
    test_timeout();
    test_enable();
    test_saturation();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
